// File: rtl/rat_io_pkg.sv
// rat_io_pkg: shared types, default port IDs and elaboration helpers for rat_io_bus
package rat_io_pkg;
  typedef logic [7:0] port_id_t;
  typedef logic [7:0] io_byte_t;
  localparam port_id_t SWITCHES_ID = 8'h20;
  localparam port_id_t LEDS_ID = 8'h40;
  localparam port_id_t SSEG_ID = 8'h81;
  localparam port_id_t IRQ_MASK_ID = 8'hF0;
  localparam port_id_t IRQ_STAT_ID = 8'hF1;
  localparam int MAX_IRQ = 8;
  function automatic logic overlaps(int a, int na, int b, int nb);
    return a < b + nb && b < a + na;
  endfunction
endpackage

// File: rtl/rat_io_bus_irq_capture.sv
// irq_capture: synchronised edge capture into sticky W1C pending bits, mask register and registered INTR
module irq_capture
  import rat_io_pkg::*;
#(
  parameter int NUM_IRQ = 4
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic [NUM_IRQ-1:0] IRQ_SRC,
  input  logic               mask_we,
  input  logic               stat_we,
  input  logic [NUM_IRQ-1:0] wbits,
  output logic [NUM_IRQ-1:0] pending,
  output logic [NUM_IRQ-1:0] mask,
  output logic               INTR
);
  logic [NUM_IRQ-1:0] sync1, sync2, prev;
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      sync1 <= '0;
      sync2 <= '0;
      prev <= '0;
      pending <= '0;
      mask <= '0;
      INTR <= 1'b0;
    end else begin
      sync1 <= IRQ_SRC;
      sync2 <= sync1;
      prev <= sync2;
      pending <= (pending & ~(stat_we ? wbits : '0)) | (sync2 & ~prev);
      mask <= mask_we ? wbits : mask;
      INTR <= |(pending & mask);
    end
endmodule

// File: rtl/rat_io_bus.sv
// rat_io_bus: RAT MCU port-bus hub with input ports, output registers and edge-captured interrupts
// Define RAT_IO_READBACK_EN to make output registers readable at their own IDs.
module rat_io_bus
  import rat_io_pkg::*;
#(
  parameter int       NUM_IN      = 2,
  parameter int       NUM_OUT     = 4,
  parameter int       NUM_IRQ     = 4,
  parameter port_id_t IN_BASE     = SWITCHES_ID,
  parameter port_id_t OUT_BASE    = LEDS_ID,
  parameter port_id_t IRQ_MASK_ID = rat_io_pkg::IRQ_MASK_ID,
  parameter port_id_t IRQ_STAT_ID = rat_io_pkg::IRQ_STAT_ID
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic [7:0]           PORT_ID,
  input  logic [7:0]           OUT_PORT,
  input  logic                 IO_STRB,
  output logic [7:0]           IN_PORT,
  input  logic [8*NUM_IN-1:0]  IN_DATA,
  output logic [8*NUM_OUT-1:0] OUT_DATA,
  input  logic [NUM_IRQ-1:0]   IRQ_SRC,
  output logic                 INTR
);
  localparam bit OVERLAP =
    overlaps(int'(IN_BASE), NUM_IN, int'(OUT_BASE), NUM_OUT) ||
    overlaps(int'(IN_BASE), NUM_IN, int'(IRQ_MASK_ID), 1) ||
    overlaps(int'(IN_BASE), NUM_IN, int'(IRQ_STAT_ID), 1) ||
    overlaps(int'(OUT_BASE), NUM_OUT, int'(IRQ_MASK_ID), 1) ||
    overlaps(int'(OUT_BASE), NUM_OUT, int'(IRQ_STAT_ID), 1) ||
    IRQ_MASK_ID == IRQ_STAT_ID;
  if (NUM_IRQ < 1 || NUM_IRQ > MAX_IRQ) begin : g_bad_irq
    $error("rat_io_bus: NUM_IRQ must be 1..%0d", MAX_IRQ);
  end
  if (OVERLAP) begin : g_overlap
    $error("rat_io_bus: port ID ranges overlap");
  end
  logic [NUM_IRQ-1:0] pending, mask;
  logic mask_we, stat_we;
  assign mask_we = IO_STRB && PORT_ID == IRQ_MASK_ID;
  assign stat_we = IO_STRB && PORT_ID == IRQ_STAT_ID;
  irq_capture #(.NUM_IRQ(NUM_IRQ)) u_irq (
    .CLK(CLK),
    .RST_N(RST_N),
    .IRQ_SRC(IRQ_SRC),
    .mask_we(mask_we),
    .stat_we(stat_we),
    .wbits(OUT_PORT[NUM_IRQ-1:0]),
    .pending(pending),
    .mask(mask),
    .INTR(INTR)
  );
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) OUT_DATA <= '0;
    else if (IO_STRB)
      for (int j = 0; j < NUM_OUT; j++)
        if (PORT_ID == port_id_t'(int'(OUT_BASE) + j)) OUT_DATA[8*j +: 8] <= OUT_PORT;
  always_comb begin
    IN_PORT = '0;
    for (int i = 0; i < NUM_IN; i++)
      if (PORT_ID == port_id_t'(int'(IN_BASE) + i)) IN_PORT = IN_DATA[8*i +: 8];
`ifdef RAT_IO_READBACK_EN
    for (int j = 0; j < NUM_OUT; j++)
      if (PORT_ID == port_id_t'(int'(OUT_BASE) + j)) IN_PORT = OUT_DATA[8*j +: 8];
`endif
    if (PORT_ID == IRQ_STAT_ID) IN_PORT = io_byte_t'(pending);
    if (PORT_ID == IRQ_MASK_ID) IN_PORT = io_byte_t'(mask);
  end
endmodule

// File: doc/rat_io_bus.md
# rat_io_bus

Parametrised port-mapped I/O hub between the RAT MCU port bus (PORT_ID / OUT_PORT / IO_STRB / IN_PORT) and board peripherals. It replaces the hand-written switch/LED/SSEG decode with NUM_IN input ports and NUM_OUT output registers at configurable base IDs. It adds an interrupt controller that captures edges from NUM_IRQ sources into a pending register, and drives the MCU interrupt line. Pending bits are maskable and clearable by software.

## Interface
- NUM_IN, 2: number of 8-bit input ports
- NUM_OUT, 4: number of 8-bit output registers
- NUM_IRQ, 4: interrupt sources, 1..8
- IN_BASE, 8'h20: port ID of input 0; input i at IN_BASE+i
- OUT_BASE, 8'h40: port ID of output 0; output j at OUT_BASE+j
- IRQ_MASK_ID, 8'hF0: mask register ID (read/write)
- IRQ_STAT_ID, 8'hF1: pending register ID (read; write-1-to-clear)

Ports:
- CLK  in  1  system clock (MCU clock domain)
- RST_N  in  1  reset; asynchronous, active-low
- PORT_ID  in  8  port ID from MCU
- OUT_PORT  in  8  write data from MCU
- IO_STRB  in  1  write strobe from MCU
- IN_PORT  out  8  read data to MCU
- IN_DATA  in  8*NUM_IN  input port i on bits [8i+7:8i]
- OUT_DATA  out  8*NUM_OUT  output register j on bits [8j+7:8j]
- IRQ_SRC  in  NUM_IRQ  asynchronous interrupt sources (debounced externally)
- INTR  out  1  interrupt request to MCU, level

## Operation
- Read decode, combinational, priority order:
  1. IRQ_MASK_ID returns mask, zero-extended to 8 bits.
  2. IRQ_STAT_ID returns pending, zero-extended to 8 bits.
  3. IN_BASE..IN_BASE+NUM_IN-1 returns the matching IN_DATA byte.
  4. Any other ID returns 8'h00.
- Write decode, on rising CLK when IO_STRB=1:
  - OUT_BASE+j: OUT_DATA byte j <= OUT_PORT.
  - IRQ_MASK_ID: mask <= OUT_PORT[NUM_IRQ-1:0].
  - IRQ_STAT_ID: pending <= pending & ~OUT_PORT[NUM_IRQ-1:0].
  - Writes to input IDs or unmapped IDs are ignored.
- Interrupt capture, per source:
  - 2-flop synchroniser, then a previous-value flop.
  - A synchronised 0->1 transition sets that pending bit.
  - Pending bits are sticky until cleared by software.
- INTR is a register: INTR <= |(pending & mask).
- Set beats clear: a capture and a W1C of the same bit in the same cycle leaves the bit set. Other bits clear normally.
- Mask does not gate capture. A masked source still latches pending; unmasking it raises INTR.
- Address-range overlap between the input, output and IRQ IDs is illegal. An elaboration-time assertion fails on overlap, or on NUM_IRQ outside 1..8.

## Timing
- Reset (RST_N=0, immediate, independent of CLK) clears: OUT_DATA, mask, pending, INTR, and all sync/previous flops. IN_PORT then reflects the decode of the reset state.
- A source already high at reset release produces one pending event. Mask is 0 after reset, so INTR stays 0.
- IN_PORT is valid in the same cycle as PORT_ID (zero latency); the MCU samples it at the next edge.
- OUT_DATA updates at the CLK edge where IO_STRB=1 and is visible one cycle after the strobe.
- IRQ latency, with IRQ_SRC rising before edge k:
  - sync1 at k, sync2 at k+1, pending at k+2, INTR at k+3.
  - Maximum 4 edges, including one edge of setup uncertainty.
- Clear latency: W1C at edge k clears pending at k; INTR falls at k+1 if no other enabled bit is pending.
- Source pulses shorter than one CLK period may be missed (the debounce upstream guarantees longer pulses).

## Configuration
- RAT_IO_READBACK_EN defined: reads of OUT_BASE+j return OUT_DATA byte j. This sits between IRQ registers and inputs in the read priority.
- Undefined: output IDs read as 8'h00, and no readback mux is generated.

## Structure
- Package rat_io_pkg holds:
  - typedefs port_id_t (logic [7:0]) and io_byte_t (logic [7:0]);
  - default ID constants SWITCHES_ID=8'h20, LEDS_ID=8'h40, SSEG_ID=8'h81, IRQ_MASK_ID, IRQ_STAT_ID;
  - MAX_IRQ=8.
- Sub-module irq_capture: synchroniser, edge detect, pending/W1C logic and mask register for NUM_IRQ sources. Outputs pending, mask and INTR.
- rat_io_bus contains address decode, the output register array and the read mux.

## Test plan
- Reset with RST_N=0 mid-write (IO_STRB=1, PORT_ID=8'h40, OUT_PORT=8'hA5) -> OUT_DATA=0, INTR=0; after release, a read of 8'hF0 returns 8'h00.
- Write 8'h3C to 8'h41 -> OUT_DATA[15:8]=8'h3C one cycle later, other bytes unchanged. A read of 8'h41 returns 8'h3C with RAT_IO_READBACK_EN and 8'h00 without.
- IN_DATA={8'h77,8'h12}: read 8'h20 -> 8'h12, 8'h21 -> 8'h77, 8'h22 -> 8'h00 in the same cycle.
- Mask=8'h01, pulse IRQ_SRC[0] for 3 cycles -> pending=8'h01 at edge k+2, INTR=1 at k+3. Write 8'h01 to 8'hF1 -> INTR=0 one cycle later.
- Mask=8'h00, pulse IRQ_SRC[2] -> pending=8'h04, INTR stays 0. Write mask 8'h04 -> INTR=1 on the next edge.
- W1C of bit 1 in the same cycle as a new capture on source 1 -> pending bit 1 remains 1 and INTR stays 1.
